// File: rtl/bin_to_bcd4_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd4_seq
// Purpose  : Bit-serial double-dabble converter, unsigned binary -> 4 BCD
//            digits over valid/ready. Optional leading-zero blanking mask
//            enabled by defining BIN2BCD_LZB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd4_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  output logic             out_valid,
  output logic [3:0]       bcd3,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0,
  output logic             ovf,
  output logic [3:0]       blank
);

  localparam int                 CNT_W      = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   C_CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]   C_CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]        C_SAT      = 16'h9999;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [15:0]       scr_q, scr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [15:0]       res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic [15:0]       corr;
  logic              in_ovf;

  // Overflow is decided once at acceptance; the scratch register is too
  // narrow to hold a fifth digit, so the final digits are simply replaced.
  assign in_ovf = (32'(in_bin) > 32'd9999);

  always_comb begin
    corr = scr_q;
    for (int i = 0; i < 4; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        corr[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d      = in_bin;
          scr_d      = '0;
          cnt_d      = C_CNT_LOAD;
          ovf_pend_d = in_ovf;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = (corr << 1) | 16'(bin_q[WIDTH-1]);
        bin_d = bin_q << 1;
        cnt_d = cnt_q - C_CNT_ONE;
        if (cnt_q == C_CNT_ONE) begin
          state_d = IDLE;
          valid_d = 1'b1;
          ovf_d   = ovf_pend_q;
          res_d   = ovf_pend_q ? C_SAT : ((corr << 1) | 16'(bin_q[WIDTH-1]));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign bcd3      = res_q[15:12];
  assign bcd2      = res_q[11:8];
  assign bcd1      = res_q[7:4];
  assign bcd0      = res_q[3:0];
  assign ovf       = ovf_q;

`ifdef BIN2BCD_LZB_EN
  logic [3:0] blank_q, blank_d;

  // Units digit is never blanked so a zero value still shows "0".
  always_comb begin
    blank_d = blank_q;
    if (valid_d) begin
      blank_d[3] = (res_d[15:12] == 4'd0);
      blank_d[2] = blank_d[3] && (res_d[11:8] == 4'd0);
      blank_d[1] = blank_d[2] && (res_d[7:4] == 4'd0);
      blank_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q <= 4'b0000;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd4_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd4_seq
// Purpose  : Scoreboard bench for bin_to_bcd4_seq at WIDTH=8 and WIDTH=14.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd4_seq;

`ifdef BIN2BCD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        v8 = 1'b0;
  logic [7:0]  b8 = '0;
  logic        r8, ov8, of8;
  logic [3:0]  d83, d82, d81, d80, bl8;

  logic        v14 = 1'b0;
  logic [13:0] b14 = '0;
  logic        r14, ov14, of14;
  logic [3:0]  d143, d142, d141, d140, bl14;

  bin_to_bcd4_seq #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_bin(b8),
    .out_valid(ov8), .bcd3(d83), .bcd2(d82), .bcd1(d81), .bcd0(d80),
    .ovf(of8), .blank(bl8)
  );

  bin_to_bcd4_seq #(.WIDTH(14)) u_w14 (
    .clk(clk), .rst(rst), .in_valid(v14), .in_ready(r14), .in_bin(b14),
    .out_valid(ov14), .bcd3(d143), .bcd2(d142), .bcd1(d141), .bcd0(d140),
    .ovf(of14), .blank(bl14)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dig;
    logic        ovf;
    logic [3:0]  blank;
    int          acc;
  } exp_t;

  exp_t sb8[$];
  exp_t sb14[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst && ov8) begin
      if (sb8.size() == 0) begin
        chk("w8_unexpected_out_valid", 1, 0);
      end else begin
        e = sb8.pop_front();
        chk("w8_digits", {d83, d82, d81, d80}, e.dig);
        chk("w8_ovf", of8, e.ovf);
        chk("w8_blank", bl8, e.blank);
        chk("w8_latency", cyc - e.acc, 9);
        chk("w8_ready_with_valid", r8, 1);
      end
    end
  end

  always @(negedge clk) begin : mon14
    exp_t e;
    if (!rst && ov14) begin
      if (sb14.size() == 0) begin
        chk("w14_unexpected_out_valid", 1, 0);
      end else begin
        e = sb14.pop_front();
        chk("w14_digits", {d143, d142, d141, d140}, e.dig);
        chk("w14_ovf", of14, e.ovf);
        chk("w14_blank", bl14, e.blank);
        chk("w14_latency", cyc - e.acc, 15);
        chk("w14_ready_with_valid", r14, 1);
      end
    end
  end

  // Issue one value; with junk=1 in_valid stays high and in_bin is scrambled
  // during the busy window, which also measures how long in_ready stays low.
  task automatic send(input bit w14, input int v, input logic [15:0] dig,
                      input logic o, input logic [3:0] bl, input bit junk);
    exp_t e;
    int   n;
    @(negedge clk);
    if (w14) begin v14 = 1'b1; b14 = 14'(v); end
    else     begin v8  = 1'b1; b8  = 8'(v);  end
    n = 0;
    while (!(w14 ? r14 : r8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1);
    e.dig   = dig;
    e.ovf   = o;
    e.blank = LZB ? bl : 4'b0000;
    e.acc   = cyc;
    if (w14) sb14.push_back(e); else sb8.push_back(e);
    @(posedge clk);
    #1;
    if (junk) begin
      n = 0;
      @(negedge clk);
      while (!(w14 ? r14 : r8) && n < 100) begin
        if (w14) b14 = 14'($urandom); else b8 = 8'($urandom);
        n++;
        @(negedge clk);
      end
      chk(w14 ? "w14_busy_cycles" : "w8_busy_cycles", n, w14 ? 14 : 8);
    end
    if (w14) v14 = 1'b0; else v8 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb8.size() + sb14.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drain", sb8.size() + sb14.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("w8_rst_ready", r8, 1);
    chk("w8_rst_out_valid", ov8, 0);
    chk("w8_rst_ovf", of8, 0);
    chk("w8_rst_digits", {d83, d82, d81, d80}, 0);
    chk("w8_rst_blank", bl8, 0);
    chk("w14_rst_ready", r14, 1);
    chk("w14_rst_out_valid", ov14, 0);
    chk("w14_rst_digits", {d143, d142, d141, d140}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state();

    send(0, 255, 16'h0255, 1'b0, 4'b1000, 1);
    send(0,   0, 16'h0000, 1'b0, 4'b1110, 0);
    send(0, 100, 16'h0100, 1'b0, 4'b1000, 0);
    send(0,   7, 16'h0007, 1'b0, 4'b1110, 0);
    send(0,  40, 16'h0040, 1'b0, 4'b1100, 0);
    send(0,  99, 16'h0099, 1'b0, 4'b1100, 0);
    drain();

    send(0, 200, 16'h0200, 1'b0, 4'b1000, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    sb8.delete();
    @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("w8_post_abort_digits", {d83, d82, d81, d80}, 0);
    chk("w8_post_abort_ready", r8, 1);
    send(0, 37, 16'h0037, 1'b0, 4'b1100, 0);
    drain();

    send(1,  9999, 16'h9999, 1'b0, 4'b0000, 0);
    send(1, 12345, 16'h9999, 1'b1, 4'b0000, 1);
    send(1,  1000, 16'h1000, 1'b0, 4'b0000, 0);
    send(1,  4095, 16'h4095, 1'b0, 4'b0000, 0);
    send(1, 16383, 16'h9999, 1'b1, 4'b0000, 0);
    send(1, 10000, 16'h9999, 1'b1, 4'b0000, 0);
    send(1,     0, 16'h0000, 1'b0, 4'b1110, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
